// File: rtl/enc_level_ctrl.sv
// Rotary-encoder level controller.
// Turns encoder detent pulses and button presses into per-channel light levels, runs the
// IDLE/ADJUST interaction FSM with an inactivity timeout, applies step acceleration with
// saturation, and offers change notifications to the light driver over valid/ready.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   left_i, right_i, btn_i    one-cycle event pulses (CCW detent, CW detent, button)
//   level_o                   live levels, channel k at [k*LEVEL_W +: LEVEL_W]
//   sel_o                     selected channel
//   active_o                  high while in ADJUST
//   upd_valid_o/upd_ready_i   update handshake
//   upd_ch_o, upd_level_o     channel and level snapshot being offered
module enc_level_ctrl #(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned LEVEL_W        = 8,
  parameter int unsigned STEP           = 1,
  parameter int unsigned FAST_STEP      = 16,
  parameter int unsigned FAST_US        = 20000,
  parameter int unsigned TIMEOUT_MS     = 2000,
  localparam int unsigned ChW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         left_i,
  input  logic                         right_i,
  input  logic                         btn_i,
  output logic [CHANNELS*LEVEL_W-1:0]  level_o,
  output logic [ChW-1:0]               sel_o,
  output logic                         active_o,
  output logic                         upd_valid_o,
  input  logic                         upd_ready_i,
  output logic [ChW-1:0]               upd_ch_o,
  output logic [LEVEL_W-1:0]           upd_level_o
);

  localparam int unsigned FastCycles    = CLOCK_FREQ_MHZ * FAST_US;
  localparam int unsigned TimeoutCycles = CLOCK_FREQ_MHZ * TIMEOUT_MS * 1000;
  localparam int unsigned FastW         = $clog2(FastCycles + 1);
  localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);

  localparam logic [LEVEL_W:0] LevelMax  = {1'b0, {LEVEL_W{1'b1}}};
  localparam logic [LEVEL_W:0] StepSlow  = (LEVEL_W + 1)'(STEP);
  localparam logic [LEVEL_W:0] StepFast  = (LEVEL_W + 1)'(FAST_STEP);
  localparam logic [ChW-1:0]   LastCh    = ChW'(CHANNELS - 1);
  localparam logic [FastW-1:0] FastLimit = FastW'(FastCycles);
  localparam logic [ToW-1:0]   ToLast    = ToW'(TimeoutCycles - 1);

  typedef enum logic [0:0] {StIdle, StAdjust} state_e;
  typedef enum logic [1:0] {DirNone, DirLeft, DirRight} dir_e;

  state_e                           state_q, state_d;
  dir_e                             last_dir_q, last_dir_d;
  logic [FastW-1:0]                 fast_cnt_q, fast_cnt_d;
  logic [ToW-1:0]                   to_cnt_q, to_cnt_d;
  logic [ChW-1:0]                   sel_q, sel_d;
  logic [CHANNELS-1:0][LEVEL_W-1:0] level_q, level_d;
  logic [CHANNELS-1:0]              dirty_q, dirty_d;
  logic [ChW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                             upd_valid_q, upd_valid_d;
  logic [ChW-1:0]                   upd_ch_q, upd_ch_d;
  logic [LEVEL_W-1:0]               upd_level_q, upd_level_d;

  logic              in_adjust, rot_acc, btn_acc, activity, lvl_chg, hs;
  dir_e              rot_dir;
  logic [LEVEL_W:0]  step, cur, sum, diff;
  logic [LEVEL_W-1:0] lvl_new;
  logic              pick_found;
  logic [ChW-1:0]    pick_ch;
  int unsigned       idx;

  function automatic logic [ChW-1:0] wrap_inc(input logic [ChW-1:0] v);
    return (v == LastCh) ? '0 : v + 1'b1;
  endfunction

  // Event decode and level arithmetic
  always_comb begin
    in_adjust = (state_q == StAdjust);
    // Opposite rotations in the same cycle cancel and are not activity.
    rot_acc   = in_adjust & (left_i ^ right_i);
    btn_acc   = in_adjust & btn_i;
    activity  = rot_acc | btn_acc;
    rot_dir   = right_i ? DirRight : DirLeft;
    step      = ((fast_cnt_q < FastLimit) && (rot_dir == last_dir_q)) ? StepFast : StepSlow;
    cur       = {1'b0, level_q[sel_q]};
    sum       = cur + step;
    diff      = cur - step;
    if (right_i) begin
      lvl_new = (sum > LevelMax) ? LevelMax[LEVEL_W-1:0] : sum[LEVEL_W-1:0];
    end else begin
      // Borrow out of the extra bit means the result went below zero.
      lvl_new = diff[LEVEL_W] ? '0 : diff[LEVEL_W-1:0];
    end
    lvl_chg = rot_acc && (lvl_new != level_q[sel_q]);
  end

  // Interaction FSM, timeout and acceleration tracking
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    to_cnt_d   = to_cnt_q;
    last_dir_d = last_dir_q;
    fast_cnt_d = fast_cnt_q;
    level_d    = level_q;

    unique case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (btn_i) state_d = StAdjust;
      end
      StAdjust: begin
        if (btn_i) sel_d = wrap_inc(sel_q);
        if (activity) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
          state_d    = StIdle;
          to_cnt_d   = '0;
          last_dir_d = DirNone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rot_acc) begin
      fast_cnt_d = '0;
      last_dir_d = rot_dir;
    end else if (fast_cnt_q < FastLimit) begin
      fast_cnt_d = fast_cnt_q + 1'b1;
    end

    if (lvl_chg) level_d[sel_q] = lvl_new;
  end

  // Update scheduler: round-robin over dirty channels starting at rr_ptr
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!pick_found && dirty_q[ChW'(idx)]) begin
        pick_found = 1'b1;
        pick_ch    = ChW'(idx);
      end
    end

    hs          = upd_valid_q & upd_ready_i;
    dirty_d     = dirty_q;
    rr_ptr_d    = rr_ptr_q;
    upd_valid_d = upd_valid_q;
    upd_ch_d    = upd_ch_q;
    upd_level_d = upd_level_q;

    // A channel that moved since its snapshot was taken stays dirty so the newer
    // value is sent later; a change landing in this cycle also re-marks it below.
    if (hs && (level_q[upd_ch_q] == upd_level_q)) dirty_d[upd_ch_q] = 1'b0;
    if (lvl_chg) dirty_d[sel_q] = 1'b1;

    if (hs) begin
      upd_valid_d = 1'b0;
      rr_ptr_d    = wrap_inc(upd_ch_q);
    end else if (!upd_valid_q && pick_found) begin
      upd_valid_d = 1'b1;
      upd_ch_d    = pick_ch;
      upd_level_d = level_q[pick_ch];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      last_dir_q  <= DirNone;
      fast_cnt_q  <= '0;
      to_cnt_q    <= '0;
      sel_q       <= '0;
      level_q     <= '0;
      dirty_q     <= '0;
      rr_ptr_q    <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      upd_level_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      fast_cnt_q  <= fast_cnt_d;
      to_cnt_q    <= to_cnt_d;
      sel_q       <= sel_d;
      level_q     <= level_d;
      dirty_q     <= dirty_d;
      rr_ptr_q    <= rr_ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
      upd_level_q <= upd_level_d;
    end
  end

  assign level_o     = level_q;
  assign sel_o       = sel_q;
  assign active_o    = (state_q == StAdjust);
  assign upd_valid_o = upd_valid_q;
  assign upd_ch_o    = upd_ch_q;
  assign upd_level_o = upd_level_q;

endmodule

// File: tb/tb_enc_level_ctrl.sv
// Directed bench for enc_level_ctrl. Scaled timing: 1 MHz clock, fast window 50 cycles,
// inactivity timeout 1000 cycles.
module tb_enc_level_ctrl;

  localparam int unsigned Ch = 4;
  localparam int unsigned Lw = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          left, right, btn, ready;
  logic [Ch*Lw-1:0] level;
  logic [1:0]    sel, upd_ch;
  logic          active, upd_valid;
  logic [Lw-1:0] upd_level;

  int n_vec = 0;
  int n_err = 0;

  int hs_cnt = 0;
  int hs_ch  [0:255];
  int hs_lvl [0:255];
  int hs_save;

  enc_level_ctrl #(
    .CLOCK_FREQ_MHZ(1),
    .CHANNELS      (Ch),
    .LEVEL_W       (Lw),
    .STEP          (1),
    .FAST_STEP     (16),
    .FAST_US       (50),
    .TIMEOUT_MS    (1)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .left_i     (left),
    .right_i    (right),
    .btn_i      (btn),
    .level_o    (level),
    .sel_o      (sel),
    .active_o   (active),
    .upd_valid_o(upd_valid),
    .upd_ready_i(ready),
    .upd_ch_o   (upd_ch),
    .upd_level_o(upd_level)
  );

  always #5 clk = ~clk;

  // Log every accepted update.
  always @(posedge clk) begin
    if (rst_n && upd_valid && ready && hs_cnt < 256) begin
      hs_ch[hs_cnt]  = int'(upd_ch);
      hs_lvl[hs_cnt] = int'(upd_level);
      hs_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int k);
    return 32'(level[k*Lw +: Lw]);
  endfunction

  // Drive a one-cycle pulse starting at the current negedge.
  task automatic pulse(input logic r, input logic l, input logic b);
    right = r; left = l; btn = b;
    @(negedge clk);
    right = 1'b0; left = 1'b0; btn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] exp_sel [0:4];

  initial begin
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3;
    exp_sel[3] = 2'd0; exp_sel[4] = 2'd1;
    rst_n = 1'b0; left = 1'b0; right = 1'b0; btn = 1'b0; ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_level", level, 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_ch", 32'(upd_ch), 32'd0);
    chk("rst_uplvl", 32'(upd_level), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Rotation ignored in IDLE, then enter ADJUST
    ready = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    chk("idle_ignore", lvl(0), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("enter_active", 32'(active), 32'd1);
    chk("enter_sel", 32'(sel), 32'd0);

    // Slow rotations
    pulse(1'b1, 1'b0, 1'b0);
    chk("slow1", lvl(0), 32'd1);
    idle(60);
    pulse(1'b1, 1'b0, 1'b0);
    chk("slow2", lvl(0), 32'd2);
    idle(60);
    pulse(1'b1, 1'b0, 1'b0);
    chk("slow3", lvl(0), 32'd3);
    idle(10);
    chk("upd_count_le3", 32'(hs_cnt <= 3), 32'd1);
    chk("upd_last_ch", 32'(hs_ch[hs_cnt-1]), 32'd0);
    chk("upd_last_lvl", 32'(hs_lvl[hs_cnt-1]), 32'd3);
    chk("upd_idle", 32'(upd_valid), 32'd0);

    // Acceleration and direction changes
    idle(60);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_slow", lvl(0), 32'd4);
    idle(9);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_fast", lvl(0), 32'd20);
    idle(9);
    pulse(1'b0, 1'b1, 1'b0);
    chk("acc_dirchg", lvl(0), 32'd19);
    idle(9);
    pulse(1'b0, 1'b1, 1'b0);
    chk("acc_fast_left", lvl(0), 32'd3);
    idle(9);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_dirchg2", lvl(0), 32'd4);
    idle(49);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_edge_fast", lvl(0), 32'd20);
    idle(50);
    pulse(1'b1, 1'b0, 1'b0);
    chk("acc_edge_slow", lvl(0), 32'd21);

    // Saturation at the top
    for (int i = 0; i < 16; i++) begin
      idle(9);
      pulse(1'b1, 1'b0, 1'b0);
    end
    chk("sat_hi", lvl(0), 32'd255);
    idle(10);
    hs_save = hs_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    idle(10);
    chk("sat_hi_hold", lvl(0), 32'd255);
    chk("sat_hi_nodirty", 32'(hs_cnt), 32'(hs_save));

    // Saturation at the bottom
    idle(9);
    pulse(1'b0, 1'b1, 1'b0);
    chk("dn_first", lvl(0), 32'd254);
    for (int i = 0; i < 16; i++) begin
      idle(9);
      pulse(1'b0, 1'b1, 1'b0);
    end
    chk("sat_lo", lvl(0), 32'd0);
    idle(10);
    hs_save = hs_cnt;
    pulse(1'b0, 1'b1, 1'b0);
    idle(10);
    chk("sat_lo_hold", lvl(0), 32'd0);
    chk("sat_lo_nodirty", 32'(hs_cnt), 32'(hs_save));

    // Channel selection wraps
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      chk("sel_step", 32'(sel), 32'(exp_sel[i]));
      idle(1);
    end

    // Button with rotation: rotation hits old channel
    pulse(1'b1, 1'b0, 1'b1);
    chk("btnrot_lvl1", lvl(1), 32'd1);
    chk("btnrot_sel", 32'(sel), 32'd2);

    // Cancelled rotation does not touch the timeout
    idle(500);
    pulse(1'b1, 1'b1, 1'b0);
    chk("lr_cancel", lvl(2), 32'd0);
    idle(497);
    chk("to_before2", 32'(active), 32'd1);
    idle(1);
    chk("to_before1", 32'(active), 32'd1);
    idle(1);
    chk("to_expired", 32'(active), 32'd0);
    chk("to_sel_kept", 32'(sel), 32'd2);
    pulse(1'b1, 1'b0, 1'b0);
    chk("to_ignore", lvl(2), 32'd0);

    // Backpressure: snapshot stability, re-send and round-robin
    ready = 1'b0;
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    chk("bp_sel1", 32'(sel), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("bp_lvl1a", lvl(1), 32'd2);
    idle(2);
    chk("bp_valid", 32'(upd_valid), 32'd1);
    chk("bp_ch", 32'(upd_ch), 32'd1);
    chk("bp_snap", 32'(upd_level), 32'd2);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("bp_lvl3", lvl(3), 32'd16);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b0, 1'b1); idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("bp_lvl1b", lvl(1), 32'd18);
    chk("bp_hold_ch", 32'(upd_ch), 32'd1);
    chk("bp_hold_snap", 32'(upd_level), 32'd2);
    hs_save = hs_cnt;
    ready = 1'b1;
    @(negedge clk);
    chk("bp_bubble", 32'(upd_valid), 32'd0);
    @(negedge clk);
    chk("bp_rr_valid", 32'(upd_valid), 32'd1);
    chk("bp_rr_ch", 32'(upd_ch), 32'd3);
    chk("bp_rr_lvl", 32'(upd_level), 32'd16);
    idle(6);
    chk("bp_hs_count", 32'(hs_cnt - hs_save), 32'd3);
    chk("bp_hs0_ch", 32'(hs_ch[hs_save]), 32'd1);
    chk("bp_hs0_lvl", 32'(hs_lvl[hs_save]), 32'd2);
    chk("bp_hs2_ch", 32'(hs_ch[hs_save+2]), 32'd1);
    chk("bp_hs2_lvl", 32'(hs_lvl[hs_save+2]), 32'd18);
    pulse(1'b1, 1'b1, 1'b0);
    chk("bp_lr_cancel", lvl(1), 32'd18);

    // Asynchronous reset with an offer pending
    ready = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("ar_lvl", lvl(1), 32'd34);
    idle(2);
    chk("ar_pre_valid", 32'(upd_valid), 32'd1);
    chk("ar_pre_active", 32'(active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level", level, 32'd0);
    chk("ar_sel", 32'(sel), 32'd0);
    chk("ar_active", 32'(active), 32'd0);
    chk("ar_valid", 32'(upd_valid), 32'd0);
    chk("ar_ch", 32'(upd_ch), 32'd0);
    chk("ar_uplvl", 32'(upd_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("ar_idle_ignore", level, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
